// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The controller side uses the master modport, the arithmetic unit the slave modport.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             v;

  modport master (
    output start, a, b, m,
    input  ready, busy, done, s, c, v
  );

  modport slave (
    input  start, a, b, m,
    output ready, busy, done, s, c, v
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder slice, LSB first, WIDTH cycles per op.
// Optional macro ADDSUB_SAT_EN saturates s to the signed extreme on overflow.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_addsub_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] res_final;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_q;
  logic             v_q;
  logic             sum_bit;
  logic             carry_nxt;
  logic             ovf;
  logic             accept;
  logic             last_bit;

  assign accept    = bus.start && (state != RUN);
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign sum_bit   = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign res_full  = {sum_bit, sh_r[WIDTH-1:1]};
  // On the MSB cycle, carry still holds the carry into the MSB.
  assign ovf       = carry ^ carry_nxt;

`ifdef ADDSUB_SAT_EN
  // Overflow flips the sign, so a negative-looking result means positive overflow.
  assign res_final = ovf ? (res_full[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                              : {1'b1, {(WIDTH-1){1'b0}}})
                         : res_full;
`else
  assign res_final = res_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:    bus.ready = 1'b1;
      RUN:     bus.busy  = 1'b1;
      DONE: begin
        bus.ready = 1'b1;
        bus.done  = 1'b1;
      end
      default: bus.ready = 1'b0;
    endcase
  end

  // Subtract is a + ~b + 1: the inverted operand and the carry seed are set on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_r  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (accept) begin
      sh_a  <= bus.a;
      sh_b  <= bus.m ? ~bus.b : bus.b;
      carry <= bus.m;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sh_r  <= res_full;
      carry <= carry_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        s_q <= res_final;
        c_q <= carry_nxt;
        v_q <= ovf;
      end
    end
  end

  assign bus.s = s_q;
  assign bus.c = c_q;
  assign bus.v = v_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): reference model with a result scoreboard,
// plus directed arithmetic, handshake and reset-abort cases.
module tb_serial_addsub;

  localparam int W = 8;

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] EXP_OVF_ADD = 8'h7F;
  localparam logic [W-1:0] EXP_OVF_SUB = 8'h80;
`else
  localparam logic [W-1:0] EXP_OVF_ADD = 8'h80;
  localparam logic [W-1:0] EXP_OVF_SUB = 8'h7F;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

  logic    clk   = 1'b0;
  logic    rst_n = 1'b0;
  int      tests = 0;
  int      fails = 0;
  res_t    sb[$];
  res_t    held  = '{s: '0, c: 1'b0, v: 1'b0};
  mstate_t mst   = M_IDLE;
  int      mcnt  = 0;

  logic [W-1:0] hold_a [3] = '{8'h11, 8'h40, 8'h90};
  logic [W-1:0] hold_b [3] = '{8'h22, 8'h05, 8'h10};
  logic         hold_m [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] hold_s [3] = '{8'h33, 8'h3B, 8'hA0};

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                    input logic m_i);
    logic [W-1:0] be;
    logic [W:0]   sum;
    res_t         r;
    be  = m_i ? ~b_i : b_i;
    sum = {1'b0, a_i} + {1'b0, be} + (W+1)'(m_i);
    r.s = sum[W-1:0];
    r.c = sum[W];
    r.v = (a_i[W-1] == be[W-1]) && (sum[W-1] != a_i[W-1]);
`ifdef ADDSUB_SAT_EN
    if (r.v) r.s = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the handshake; results are queued on accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst  = M_IDLE;
      mcnt = 0;
      sb.delete();
      held = '{s: '0, c: 1'b0, v: 1'b0};
    end else begin
      case (mst)
        M_IDLE: if (bus.start) begin
          sb.push_back(model_op(bus.a, bus.b, bus.m));
          mst  = M_RUN;
          mcnt = 0;
        end
        M_RUN: begin
          mcnt++;
          if (mcnt == W) mst = M_DONE;
        end
        M_DONE: if (bus.start) begin
          sb.push_back(model_op(bus.a, bus.b, bus.m));
          mst  = M_RUN;
          mcnt = 0;
        end else begin
          mst = M_IDLE;
        end
        default: mst = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check_output("mon.ready", bus.ready, mst != M_RUN);
      check_output("mon.busy",  bus.busy,  mst == M_RUN);
      check_output("mon.done",  bus.done,  mst == M_DONE);
      if (mst == M_DONE) begin
        check_output("mon.sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) held = sb.pop_front();
      end
      check_output("mon.s", bus.s, held.s);
      check_output("mon.c", bus.c, held.c);
      check_output("mon.v", bus.v, held.v);
    end
  end

  task automatic apply_stimulus(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic m_i);
    @(negedge clk);
    bus.a     = a_i;
    bus.b     = b_i;
    bus.m     = m_i;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.m     = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic m_i, input logic [W-1:0] es, input logic ec, input logic ev);
    int n;
    apply_stimulus(a_i, b_i, m_i);
    n = 0;
    while (bus.done !== 1'b1 && n < 3*W) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, ".latency"}, n, W);
    check_output({tag, ".s"}, bus.s, es);
    check_output({tag, ".c"}, bus.c, ec);
    check_output({tag, ".v"}, bus.v, ev);
  endtask

  initial begin
    int   n;
    int   seen;
    res_t r;
    logic [W-1:0] ra, rb;
    logic rm;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.m     = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst.ready", bus.ready, 1);
    check_output("rst.busy",  bus.busy,  0);
    check_output("rst.done",  bus.done,  0);
    check_output("rst.s",     bus.s,     0);
    check_output("rst.c",     bus.c,     0);
    check_output("rst.v",     bus.v,     0);
    rst_n = 1'b1;

    run_op("add",      8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0);
    run_op("carry",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("borrow",   8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("noborrow", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op("ovf_add",  8'h7F, 8'h01, 1'b0, EXP_OVF_ADD, 1'b0, 1'b1);
    run_op("ovf_sub",  8'h80, 8'h01, 1'b1, EXP_OVF_SUB, 1'b1, 1'b1);

    // Extra start pulses while running must neither queue nor shift the completion.
    apply_stimulus(8'h30, 8'h0F, 1'b0);
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    repeat (W-2) @(negedge clk) bus.start = ~bus.start;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk);
    check_output("extra.done", bus.done, 1);
    check_output("extra.s",    bus.s,    8'h3F);
    @(negedge clk);
    check_output("extra.idle_done", bus.done, 0);

    @(negedge clk);
    bus.a     = hold_a[0];
    bus.b     = hold_b[0];
    bus.m     = hold_m[0];
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (bus.done !== 1'b1 && n < 3*W);
      check_output($sformatf("held%0d.period", k), n, W+1);
      check_output($sformatf("held%0d.s", k), bus.s, hold_s[k]);
      if (k < 2) begin
        bus.a = hold_a[k+1];
        bus.b = hold_b[k+1];
        bus.m = hold_m[k+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    // Abort in RUN cycle 4: outputs must return to reset values with no completion.
    apply_stimulus(8'h55, 8'h22, 1'b0);
    repeat (4) @(negedge clk);
    check_output("abort.busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("abort.ready", bus.ready, 1);
    check_output("abort.busy",  bus.busy,  0);
    check_output("abort.done",  bus.done,  0);
    check_output("abort.s",     bus.s,     0);
    check_output("abort.c",     bus.c,     0);
    check_output("abort.v",     bus.v,     0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (W+2) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check_output("abort.no_done", seen, 0);
    run_op("post_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rm = 1'($urandom);
      r  = model_op(ra, rb, rm);
      run_op($sformatf("rand%0d", i), ra, rb, rm, r.s, r.c, r.v);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor built around a single full-adder slice with a registered carry.
- Processes one bit per clock, LSB first, and needs WIDTH cycles per operation.
- Uses a start/ready/done handshake.
- Reports carry/borrow and signed overflow.
- Generalises the team's 1-bit combinational add/sub cell to WIDTH bits with sequencing. Sits as the arithmetic unit under the lab datapath controller.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  operand A; latched when start is accepted
- b  input  WIDTH  operand B; latched when start is accepted
- m  input  1  mode, latched with operands: 0 = a+b, 1 = a-b
- ready  output  1  high in IDLE and DONE; start is accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- s  output  WIDTH  result; held until the next completion
- c  output  1  carry-out (add); for subtract, 1 = no borrow (a>=b unsigned)
- v  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, ready=1, busy=0, done=0, s=0, c=0, v=0, internal shift registers and bit counter = 0. Reset asserted mid-operation aborts the operation: no done pulse, outputs return to reset values.
- States:
  - IDLE: ready=1. If start=1, go to RUN.
  - RUN: busy=1, ready=0. Stays in RUN for exactly WIDTH cycles, then goes to DONE.
  - DONE: done=1, ready=1, for exactly one cycle. If start=1, go to RUN; otherwise go to IDLE.
- On accept (start=1 && ready=1):
  - Latch a into shift register A.
  - Latch (m ? ~b : b) into shift register B.
  - Carry register <= m (two's-complement subtract).
  - Bit counter <= 0.
- Each RUN cycle:
  - sum_bit = A[0] ^ B[0] ^ carry.
  - carry <= majority(A[0], B[0], carry).
  - sum_bit shifts into the MSB of the result shift register; A and B shift right.
  - Bit counter increments.
  - On the bit WIDTH-1 cycle, the carry-in is captured for v.
- Completion: on the edge ending RUN cycle WIDTH-1, s/c/v are loaded from the result shift register and final carry in the same edge that enters DONE.
  - s, c, v never change during RUN; they show the previous result.
- Latency: start accepted at edge T0 -> done high in the cycle following edge T(WIDTH).
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored and not queued.
- Operand inputs a, b, m may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH; c and v are defined exactly as in the Ports section regardless of how operands are interpreted.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when signed overflow occurs, s saturates to the signed extreme and v still reports the overflow; c is unchanged.
  - Positive overflow (both effective operands non-negative) -> s = 0x7F..F.
  - Negative overflow -> s = 0x80..0.
- Undefined: s is the wrapped modulo-2^WIDTH result; no saturation logic is present.

Test Plan (WIDTH=8):
- Add: a=0x25, b=0x13, m=0, start pulse -> done exactly 8 cycles after the accept edge; s=0x38, c=0, v=0; busy high for 8 cycles.
- Unsigned carry: 0xFF+0x01 -> s=0x00, c=1, v=0.
- Subtract with borrow: 0x05-0x07 -> s=0xFE, c=0, v=0.
- Subtract without borrow: 0x07-0x05 -> s=0x02, c=1, v=0.
- Signed overflow: 0x7F+0x01 -> s=0x80, c=0, v=1 (with ADDSUB_SAT_EN: s=0x7F).
  - 0x80-0x01 -> s=0x7F, c=1, v=1 (with ADDSUB_SAT_EN: s=0x80).
- Control corners:
  - Extra start pulses during RUN cause no effect and keep the done timing.
  - start held high continuously -> done pulses every 9 cycles with correct results.
  - rst_n low in RUN cycle 4 -> all outputs at reset values and no done pulse; the next operation (0x10+0x20) yields s=0x30.
